// File: rtl/poci_keys_irq.sv
`default_nettype none
// ============================================================================
// Module   : poci_keys_irq
// Brief    : POCI slave that debounces 4 push-keys and 10 slide switches,
//            latches their events and raises a maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module poci_keys_irq #(
   parameter int TICK_DIV = 50000,
   parameter int DB_COUNT = 8
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [11:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic [3:0]  key,
   input  logic [9:0]  sw,
   output logic        irq
);
   localparam int          C_PW      = $clog2(TICK_DIV);
   localparam logic [13:0] C_IN_RST  = 14'h000F;
   localparam logic [7:0]  C_DB_LAST = 8'(DB_COUNT - 1);

   logic [13:0]     r_sync1, r_sync2;
   logic [C_PW-1:0] r_presc;
   logic            w_tick;
   logic [13:0]     r_deb, r_deb_q;
   logic [7:0]      r_cnt [14];
   logic [1:0]      r_settle;
   logic [3:0]      r_armed;
   logic [13:0]     w_evt, w_w1c;
   logic [13:0]     r_pending, r_mask;
   logic            r_irq;
   logic            w_wr;
   logic            w_unused_pwdata;

   assign pready          = 1'b1;
   assign pslverr         = 1'b0;
   assign irq             = r_irq;
   assign w_unused_pwdata = ^pwdata[31:14];

   // keys occupy bits [3:0], switches bits [13:4] throughout
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_sync1 <= C_IN_RST;
         r_sync2 <= C_IN_RST;
      end else begin
         r_sync1 <= {sw, key};
         r_sync2 <= r_sync1;
      end
   end

   assign w_tick = (r_presc == C_PW'(TICK_DIV - 1));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) r_presc <= '0;
      else          r_presc <= w_tick ? '0 : r_presc + C_PW'(1);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_deb <= C_IN_RST;
         for (int i = 0; i < 14; i++) r_cnt[i] <= '0;
      end else if (w_tick) begin
         for (int i = 0; i < 14; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == C_DB_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else if (r_cnt[i] != 8'hFF) begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

   // A key only arms once it has been seen released after reset, so a key
   // held down through reset never reports a press.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_deb_q  <= C_IN_RST;
         r_settle <= '0;
         r_armed  <= '0;
      end else begin
         r_deb_q <= r_deb;
         if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
         r_armed <= r_armed | ({4{r_settle == 2'd2}} & r_sync2[3:0]);
      end
   end

   assign w_evt[3:0]  = r_deb_q[3:0] & ~r_deb[3:0] & r_armed;
   assign w_evt[13:4] = r_deb_q[13:4] ^ r_deb[13:4];

   assign w_wr  = psel & penable & pwrite;
   assign w_w1c = (w_wr && paddr == 12'h004) ? pwdata[13:0] : 14'h0;

   // new events are OR-ed in after the clear, so a same-cycle event wins
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_pending <= '0;
         r_mask    <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_w1c) | w_evt;
         if (w_wr && paddr == 12'h008) r_mask <= pwdata[13:0];
         r_irq <= |(r_pending & r_mask);
      end
   end

   always_comb begin
      prdata = '0;
      if (psel && !pwrite) begin
         case (paddr)
            12'h000: prdata = {18'b0, r_deb[13:4], ~r_deb[3:0]};
            12'h004: prdata = {18'b0, r_pending};
            12'h008: prdata = {18'b0, r_mask};
            12'h00C: prdata = {18'b0, r_sync2[13:4], ~r_sync2[3:0]};
            default: prdata = '0;
         endcase
      end
   end

endmodule
`default_nettype wire
